// File: rtl/rv_soc_pkg.sv
// Shared SoC constants and the fetch-buffer entry type used between core, ROM and prefetch logic.
package rv_soc_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ROM_DEPTH  = 1024;
  localparam int unsigned ADDR_WIDTH = $clog2(ROM_DEPTH);
  localparam int unsigned RESET_PC   = 0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_buf_if.sv
// Core-side fetch handshake plus ROM read port of the instruction prefetch buffer.
interface instr_prefetch_buf_if #(
  parameter int unsigned DATA_WIDTH = rv_soc_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = rv_soc_pkg::ADDR_WIDTH
);

  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  instr_valid_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  instr_ready_i;
  logic                  rom_en_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;

  // master: the prefetch buffer; slave: the core and ROM around it.
  modport master (
    input  redirect_i, redirect_pc_i, instr_ready_i, rom_data_i,
    output instr_valid_o, instr_o, instr_pc_o, rom_en_o, rom_addr_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, instr_ready_i, rom_data_i,
    input  instr_valid_o, instr_o, instr_pc_o, rom_en_o, rom_addr_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head data is presented combinationally.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [Width-1:0]           o_data,
  output logic [$clog2(Depth):0]     o_count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // A push into a full FIFO is legal only alongside a pop of the same slot.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: sequential fetch address, fixed-latency ROM return pipeline,
// credit-limited issue into a small FIFO, and redirect with full flush.
module instr_prefetch_buf #(
  parameter int unsigned DATA_WIDTH  = rv_soc_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = rv_soc_pkg::ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ROM_LATENCY = 0,
  parameter int unsigned RESET_PC    = rv_soc_pkg::RESET_PC
) (
  input logic                  clk,
  input logic                  rstn,
  instr_prefetch_buf_if.master bus
);

  localparam int unsigned EntryW = DATA_WIDTH + ADDR_WIDTH;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW   = CntW + 2;

  logic                  r_run;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_ret_vld;
  logic [ADDR_WIDTH-1:0] w_ret_pc;
  logic [OccW-1:0]       w_inflight;
  logic [OccW-1:0]       w_occ;
  logic [CntW-1:0]       w_count;
  logic [EntryW-1:0]     w_head;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & bus.instr_ready_i;

  // Credit check covers buffered and in-flight words; the pop frees a slot this edge.
  assign w_occ   = OccW'(w_count) + w_inflight - OccW'(w_pop);
  assign w_issue = r_run & ~bus.redirect_i & (w_occ < OccW'(FIFO_DEPTH));
  assign w_push  = w_ret_vld & ~bus.redirect_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run      <= 1'b0;
      r_fetch_pc <= ADDR_WIDTH'(RESET_PC);
    end else begin
      r_run <= 1'b1;
      if (bus.redirect_i) begin
        r_fetch_pc <= bus.redirect_pc_i;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
      end
    end
  end

  if (ROM_LATENCY == 0) begin : g_comb_rom
    assign w_inflight = '0;
    assign w_ret_vld  = w_issue;
    assign w_ret_pc   = r_fetch_pc;
  end else begin : g_rom_pipe
    logic                  r_pipe_vld [ROM_LATENCY];
    logic [ADDR_WIDTH-1:0] r_pipe_pc  [ROM_LATENCY];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
          r_pipe_vld[i] <= 1'b0;
          r_pipe_pc[i]  <= '0;
        end
      end else begin
        r_pipe_vld[0] <= w_issue;
        r_pipe_pc[0]  <= r_fetch_pc;
        for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
          r_pipe_vld[i] <= r_pipe_vld[i-1] & ~bus.redirect_i;
          r_pipe_pc[i]  <= r_pipe_pc[i-1];
        end
      end
    end

    always_comb begin
      w_inflight = '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        w_inflight = w_inflight + OccW'(r_pipe_vld[i]);
      end
    end

    assign w_ret_vld = r_pipe_vld[ROM_LATENCY-1];
    assign w_ret_pc  = r_pipe_pc[ROM_LATENCY-1];
  end

  sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  ({bus.rom_data_i, w_ret_pc}),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_i),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign bus.instr_valid_o = w_valid;
  assign bus.instr_o       = w_head[EntryW-1:ADDR_WIDTH];
  assign bus.instr_pc_o    = w_head[ADDR_WIDTH-1:0];
  assign bus.rom_en_o      = w_issue;
  assign bus.rom_addr_o    = r_fetch_pc;

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Scenario bench for instr_prefetch_buf: four configurations, scoreboarded instruction stream.
module tb_instr_prefetch_buf;
  import rv_soc_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  fetch_entry_t sb_q[$];
  fetch_entry_t exp_e;

  instr_prefetch_buf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) a_if ();
  instr_prefetch_buf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b_if ();
  instr_prefetch_buf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) c_if ();
  instr_prefetch_buf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  d_if ();

  instr_prefetch_buf #(.FIFO_DEPTH(4), .ROM_LATENCY(0)) u_a (.clk(clk), .rstn(rstn), .bus(a_if));
  instr_prefetch_buf #(.FIFO_DEPTH(4), .ROM_LATENCY(2)) u_b (.clk(clk), .rstn(rstn), .bus(b_if));
  instr_prefetch_buf #(.FIFO_DEPTH(4), .ROM_LATENCY(3)) u_c (.clk(clk), .rstn(rstn), .bus(c_if));
  instr_prefetch_buf #(.ADDR_WIDTH(4), .FIFO_DEPTH(4), .ROM_LATENCY(1), .RESET_PC(14)) u_d (
    .clk(clk), .rstn(rstn), .bus(d_if));

  // ROM models: word = 0x1000_0000 | address, delayed by each DUT's ROM latency.
  logic [9:0] b_d1, b_d2, c_d1, c_d2, c_d3;
  logic [3:0] d_d1;
  always @(posedge clk) begin
    b_d1 <= b_if.rom_addr_o;
    b_d2 <= b_d1;
    c_d1 <= c_if.rom_addr_o;
    c_d2 <= c_d1;
    c_d3 <= c_d2;
    d_d1 <= d_if.rom_addr_o;
  end
  assign a_if.rom_data_i = 32'h1000_0000 | {22'b0, a_if.rom_addr_o};
  assign b_if.rom_data_i = 32'h1000_0000 | {22'b0, b_d2};
  assign c_if.rom_data_i = 32'h1000_0000 | {22'b0, c_d3};
  assign d_if.rom_data_i = 32'h1000_0000 | {28'b0, d_d1};

  function automatic fetch_entry_t mk(input logic [9:0] pc);
    fetch_entry_t e;
    e.instr = 32'h1000_0000 | {22'b0, pc};
    e.pc    = pc;
    return e;
  endfunction

  task automatic idle();
    a_if.redirect_i = 1'b0; a_if.redirect_pc_i = '0; a_if.instr_ready_i = 1'b0;
    b_if.redirect_i = 1'b0; b_if.redirect_pc_i = '0; b_if.instr_ready_i = 1'b0;
    c_if.redirect_i = 1'b0; c_if.redirect_pc_i = '0; c_if.instr_ready_i = 1'b0;
    d_if.redirect_i = 1'b0; d_if.redirect_pc_i = '0; d_if.instr_ready_i = 1'b0;
  endtask

  // Leaves the bench mid-cycle 0: the next rising edge is the first with rstn high.
  task automatic do_reset();
    rstn = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    @(negedge clk);
    n_tests++;
    if ({a_if.instr_valid_o, a_if.rom_en_o, a_if.instr_o, a_if.instr_pc_o} !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_a: got v=%b en=%b instr=%h pc=%h, expected all zero",
               a_if.instr_valid_o, a_if.rom_en_o, a_if.instr_o, a_if.instr_pc_o);
    end
    n_tests++;
    if ({c_if.instr_valid_o, c_if.rom_en_o, c_if.instr_o, c_if.instr_pc_o} !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_c: got v=%b en=%b instr=%h pc=%h, expected all zero",
               c_if.instr_valid_o, c_if.rom_en_o, c_if.instr_o, c_if.instr_pc_o);
    end
  endtask

  task automatic test_startup();
    do_reset();
    a_if.instr_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) sb_q.push_back(mk(10'(k)));
    #1;
    n_tests++;
    if (a_if.rom_en_o !== 1'b0) begin
      n_fail++; $display("FAIL startup_cycle0_en: got %b, expected 0", a_if.rom_en_o);
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_tests++;
        if ({a_if.rom_en_o, a_if.rom_addr_o, a_if.instr_valid_o} !== {1'b1, 10'd0, 1'b0}) begin
          n_fail++;
          $display("FAIL startup_first_issue: got en=%b addr=%h v=%b, expected en=1 addr=0 v=0",
                   a_if.rom_en_o, a_if.rom_addr_o, a_if.instr_valid_o);
        end
      end else begin
        n_tests++;
        exp_e = sb_q.pop_front();
        if (a_if.instr_valid_o !== 1'b1 || a_if.instr_o !== exp_e.instr ||
            a_if.instr_pc_o !== exp_e.pc) begin
          n_fail++;
          $display("FAIL startup_stream c%0d: got v=%b instr=%h pc=%h, expected v=1 instr=%h pc=%h",
                   cyc, a_if.instr_valid_o, a_if.instr_o, a_if.instr_pc_o, exp_e.instr, exp_e.pc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_iss = 0;
    logic [9:0] exp_addr = '0;
    do_reset();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (b_if.rom_en_o) begin
        n_tests++;
        if (b_if.rom_addr_o !== exp_addr) begin
          n_fail++; $display("FAIL bp_issue_addr: got %h, expected %h", b_if.rom_addr_o, exp_addr);
        end
        exp_addr = exp_addr + 10'd1;
        n_iss++;
      end
    end
    n_tests++;
    if (n_iss != 4) begin
      n_fail++; $display("FAIL bp_issue_count: got %0d, expected 4", n_iss);
    end
    for (int k = 0; k < 20; k++) sb_q.push_back(mk(10'(k)));
    b_if.instr_ready_i = 1'b1;
    #1;
    n_tests++;
    if ({b_if.rom_en_o, b_if.rom_addr_o} !== {1'b1, 10'd4}) begin
      n_fail++;
      $display("FAIL bp_resume: got en=%b addr=%h, expected en=1 addr=004",
               b_if.rom_en_o, b_if.rom_addr_o);
    end
    exp_addr = 10'd5;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (b_if.rom_en_o) begin
          n_tests++;
          if (b_if.rom_addr_o !== exp_addr) begin
            n_fail++; $display("FAIL bp_issue_addr2: got %h, expected %h", b_if.rom_addr_o, exp_addr);
          end
          exp_addr = exp_addr + 10'd1;
        end
      end
      if (b_if.instr_valid_o) begin
        n_tests++;
        exp_e = sb_q.pop_front();
        if (b_if.instr_o !== exp_e.instr || b_if.instr_pc_o !== exp_e.pc) begin
          n_fail++;
          $display("FAIL bp_pop: got instr=%h pc=%h, expected instr=%h pc=%h",
                   b_if.instr_o, b_if.instr_pc_o, exp_e.instr, exp_e.pc);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    c_if.instr_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) sb_q.push_back(mk(10'(k)));
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      if (cyc == 11) begin
        n_tests++;
        if (c_if.instr_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL redir_flush: got v=%b, expected 0", c_if.instr_valid_o);
        end
      end
      if (cyc == 15) begin
        n_tests++;
        if ({c_if.instr_valid_o, c_if.instr_pc_o} !== {1'b1, 10'h2A0}) begin
          n_fail++;
          $display("FAIL redir_target_c15: got v=%b pc=%h, expected v=1 pc=2a0",
                   c_if.instr_valid_o, c_if.instr_pc_o);
        end
      end
      if (c_if.instr_valid_o) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL redir_extra: got pc=%h, expected none", c_if.instr_pc_o);
        end else begin
          exp_e = sb_q.pop_front();
          if (c_if.instr_o !== exp_e.instr || c_if.instr_pc_o !== exp_e.pc) begin
            n_fail++;
            $display("FAIL redir_stream c%0d: got instr=%h pc=%h, expected instr=%h pc=%h",
                     cyc, c_if.instr_o, c_if.instr_pc_o, exp_e.instr, exp_e.pc);
          end
        end
      end
      if (cyc == 10) begin
        c_if.redirect_i    = 1'b1;
        c_if.redirect_pc_i = 10'h2A0;
        sb_q.delete();
        for (int k = 0; k < 8; k++) sb_q.push_back(mk(10'h2A0 + 10'(k)));
      end
      if (cyc == 11) c_if.redirect_i = 1'b0;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL redir_missing: got %0d undelivered, expected 0", sb_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_iss [4];
    exp_iss = '{4'd14, 4'd15, 4'd0, 4'd1};
    do_reset();
    d_if.instr_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back(mk({6'b0, exp_iss[k]}));
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc <= 4) begin
        n_tests++;
        if ({d_if.rom_en_o, d_if.rom_addr_o} !== {1'b1, exp_iss[cyc-1]}) begin
          n_fail++;
          $display("FAIL wrap_issue c%0d: got en=%b addr=%0d, expected en=1 addr=%0d",
                   cyc, d_if.rom_en_o, d_if.rom_addr_o, exp_iss[cyc-1]);
        end
      end
      if (d_if.instr_valid_o && sb_q.size() != 0) begin
        n_tests++;
        exp_e = sb_q.pop_front();
        if (d_if.instr_o !== exp_e.instr || d_if.instr_pc_o !== exp_e.pc[3:0]) begin
          n_fail++;
          $display("FAIL wrap_pop: got instr=%h pc=%0d, expected instr=%h pc=%0d",
                   d_if.instr_o, d_if.instr_pc_o, exp_e.instr, exp_e.pc[3:0]);
        end
      end
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_missing: got %0d undelivered, expected 0", sb_q.size());
    end
  endtask

  task automatic test_redirect_pop_return();
    do_reset();
    b_if.instr_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) sb_q.push_back(mk(10'(k)));
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 9) begin
        n_tests++;
        if (b_if.instr_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL rpr_dropped: got v=%b pc=%h, expected v=0",
                             b_if.instr_valid_o, b_if.instr_pc_o);
        end
        b_if.redirect_i = 1'b0;
      end
      if (cyc == 12) begin
        n_tests++;
        if ({b_if.instr_valid_o, b_if.instr_pc_o} !== {1'b1, 10'h155}) begin
          n_fail++; $display("FAIL rpr_target: got v=%b pc=%h, expected v=1 pc=155",
                             b_if.instr_valid_o, b_if.instr_pc_o);
        end
      end
      if (b_if.instr_valid_o) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL rpr_extra: got pc=%h, expected none", b_if.instr_pc_o);
        end else begin
          exp_e = sb_q.pop_front();
          if (b_if.instr_o !== exp_e.instr || b_if.instr_pc_o !== exp_e.pc) begin
            n_fail++;
            $display("FAIL rpr_stream c%0d: got instr=%h pc=%h, expected instr=%h pc=%h",
                     cyc, b_if.instr_o, b_if.instr_pc_o, exp_e.instr, exp_e.pc);
          end
        end
      end
      if (cyc == 8) begin
        b_if.redirect_i    = 1'b1;
        b_if.redirect_pc_i = 10'h155;
        #1;
        n_tests++;
        if (b_if.rom_en_o !== 1'b0) begin
          n_fail++; $display("FAIL rpr_no_issue: got en=%b, expected 0", b_if.rom_en_o);
        end
        sb_q.delete();
        for (int k = 0; k < 3; k++) sb_q.push_back(mk(10'h155 + 10'(k)));
      end
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rpr_missing: got %0d undelivered, expected 0", sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_if.instr_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (a_if.instr_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL areset_streaming: got v=%b, expected 1", a_if.instr_valid_o);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({a_if.instr_valid_o, a_if.rom_en_o, a_if.instr_o, a_if.instr_pc_o} !== 44'h0) begin
      n_fail++;
      $display("FAIL areset_clear: got v=%b en=%b instr=%h pc=%h, expected all zero",
               a_if.instr_valid_o, a_if.rom_en_o, a_if.instr_o, a_if.instr_pc_o);
    end
    #3 rstn = 1'b1;
    sb_q.delete();
    for (int k = 0; k < 6; k++) sb_q.push_back(mk(10'(k)));
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_tests++;
        if ({a_if.rom_en_o, a_if.rom_addr_o, a_if.instr_valid_o} !== {1'b1, 10'd0, 1'b0}) begin
          n_fail++;
          $display("FAIL areset_first_issue: got en=%b addr=%h v=%b, expected en=1 addr=0 v=0",
                   a_if.rom_en_o, a_if.rom_addr_o, a_if.instr_valid_o);
        end
      end else begin
        n_tests++;
        exp_e = sb_q.pop_front();
        if (a_if.instr_valid_o !== 1'b1 || a_if.instr_o !== exp_e.instr ||
            a_if.instr_pc_o !== exp_e.pc) begin
          n_fail++;
          $display("FAIL areset_stream c%0d: got v=%b instr=%h pc=%h, expected v=1 instr=%h pc=%h",
                   cyc, a_if.instr_valid_o, a_if.instr_o, a_if.instr_pc_o, exp_e.instr, exp_e.pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_pop_return();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
